bcd_counter4: RTL

BCD_COUNTER4 -- requirements
Module: bcd_counter4

---
 rtl/bcd_counter4_pkg.sv | 22 ++
 rtl/bcd_digit.sv | 27 ++
 rtl/bcd_counter4.sv | 84 ++++++++
 3 files changed

// File: rtl/bcd_counter4_pkg.sv
// Shared constants and the decade next-value helper for the four-digit BCD counter.
package bcd_counter4_pkg;

   localparam int                 DIGIT_W      = 4;
   localparam logic [DIGIT_W-1:0] BCD_MAX      = 4'd9;
   localparam int                 TICK_DIV_DEF = 50000000;
   localparam int                 SCAN_DIV_DEF = 25000;

   // Next decade value in the requested direction; wraps 9->0 and 0->9.
   function automatic logic [DIGIT_W-1:0] bcd_next(input logic [DIGIT_W-1:0] d,
                                                   input logic               up);
      logic [DIGIT_W-1:0] n;
      n = d;
      if (up) begin
         n = (d >= BCD_MAX) ? '0 : d + DIGIT_W'(1);
      end else begin
         n = (d == '0 || d > BCD_MAX) ? BCD_MAX : d - DIGIT_W'(1);
      end
      return n;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade cell: steps its digit when enabled and flags a carry/borrow to the next cell.
module bcd_digit
   import bcd_counter4_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               step,
   input  logic               up,
   output logic [DIGIT_W-1:0] digit,
   output logic               carry
);

   // Carry/borrow is combinational so the whole chain ripples within one edge.
   assign carry = step & (up ? (digit == BCD_MAX) : (digit == '0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit <= '0;
      end else if (clr) begin
         digit <= '0;
      end else if (step) begin
         digit <= bcd_next(digit, up);
      end
   end

endmodule

// File: rtl/bcd_counter4.sv
// Four-digit up/down BCD counter with tick prescaler, wrap pulse and free-running scan clock.
module bcd_counter4
   import bcd_counter4_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF,
   parameter int SCAN_DIV = SCAN_DIV_DEF
)(
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               EN,
   input  logic               CLR,
   input  logic               UP,
   output logic [DIGIT_W-1:0] CNT1_TMP,
   output logic [DIGIT_W-1:0] CNT2_TMP,
   output logic [DIGIT_W-1:0] CNT3_TMP,
   output logic [DIGIT_W-1:0] CNT4_TMP,
   output logic               WRAP,
   output logic               S_CLK
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [PW-1:0]      pre;
   logic [SW-1:0]      scan_cnt;
   logic               tick;
   logic [4:0]         step;
   logic [DIGIT_W-1:0] digit [4];

   assign tick    = EN & (pre == PW'(TICK_DIV - 1));
   assign step[0] = tick;

   for (genvar i = 0; i < 4; i++) begin : g_digit
      bcd_digit u_digit (
         .clk   (CLK),
         .rst_n (RST_N),
         .clr   (CLR),
         .step  (step[i]),
         .up    (UP),
         .digit (digit[i]),
         .carry (step[i+1])
      );
   end

   assign CNT1_TMP = digit[0];
   assign CNT2_TMP = digit[1];
   assign CNT3_TMP = digit[2];
   assign CNT4_TMP = digit[3];

   // Prescaler freezes while EN is low so a paused period resumes without losing a tick.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pre <= '0;
      end else if (CLR) begin
         pre <= '0;
      end else if (EN) begin
         pre <= tick ? '0 : pre + PW'(1);
      end
   end

   // A carry out of the top digit is exactly the 9999->0000 / 0000->9999 transition.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         WRAP <= 1'b0;
      end else if (CLR) begin
         WRAP <= 1'b0;
      end else begin
         WRAP <= step[4];
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         scan_cnt <= '0;
         S_CLK    <= 1'b0;
      end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
         scan_cnt <= '0;
         S_CLK    <= ~S_CLK;
      end else begin
         scan_cnt <= scan_cnt + SW'(1);
      end
   end

endmodule
